decode_ctrl_pipe: RTL and testbench

DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

---
 rtl/ctrl_pkg.sv | 41 ++++
 rtl/ctrl_decode.sv | 94 +++++++++
 rtl/decode_ctrl_pipe.sv | 142 ++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the decode/control pipeline: opcodes, alu_op codes,
// forward selects and the ctrl_t bundle. The mul field is live only under CTRL_MULDIV_EN.
package ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [1:0] ALU_OP_MEM   = 2'b00;
  localparam logic [1:0] ALU_OP_BR    = 2'b01;
  localparam logic [1:0] ALU_OP_ARITH = 2'b10;
  localparam logic [1:0] ALU_OP_JUMP  = 2'b11;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       lui;
    logic       auipc;
    logic [1:0] alu_op;
    logic       mul;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct7 decode into a ctrl_t bundle plus source-register usage.
// CTRL_MULDIV_EN selects whether funct7=0000001 on an R-type raises mul.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic       i_valid,
  input  logic [6:0] i_opcode,
  input  logic [6:0] i_funct7,
  output ctrl_t      o_ctrl,
  output logic       o_use_rs1,
  output logic       o_use_rs2
);

  logic w_is_mul;

`ifdef CTRL_MULDIV_EN
  assign w_is_mul = (i_funct7 == FUNCT7_MULDIV);
`else
  logic w_unused_funct7;
  assign w_is_mul        = 1'b0;
  assign w_unused_funct7 = ^(i_funct7 ^ FUNCT7_MULDIV);
`endif

  always_comb begin
    o_ctrl    = '0;
    o_use_rs1 = 1'b0;
    o_use_rs2 = 1'b0;
    if (i_valid) begin
      case (i_opcode)
        OP_R: begin
          o_ctrl.reg_write = 1'b1;
          o_ctrl.alu_op    = ALU_OP_ARITH;
          o_ctrl.mul       = w_is_mul;
          o_use_rs1        = 1'b1;
          o_use_rs2        = 1'b1;
        end
        OP_I: begin
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.alu_op    = ALU_OP_ARITH;
          o_use_rs1        = 1'b1;
        end
        OP_LW: begin
          o_ctrl.alu_src    = 1'b1;
          o_ctrl.mem_to_reg = 1'b1;
          o_ctrl.mem_read   = 1'b1;
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.alu_op     = ALU_OP_MEM;
          o_use_rs1         = 1'b1;
        end
        OP_SW: begin
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.mem_write = 1'b1;
          o_ctrl.alu_op    = ALU_OP_MEM;
          o_use_rs1        = 1'b1;
          o_use_rs2        = 1'b1;
        end
        OP_BR: begin
          o_ctrl.branch = 1'b1;
          o_ctrl.alu_op = ALU_OP_BR;
          o_use_rs1     = 1'b1;
          o_use_rs2     = 1'b1;
        end
        OP_LUI: begin
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.lui       = 1'b1;
          o_ctrl.alu_op    = ALU_OP_JUMP;
        end
        OP_AUIPC: begin
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.auipc     = 1'b1;
          o_ctrl.alu_op    = ALU_OP_JUMP;
        end
        OP_JAL: begin
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.jal       = 1'b1;
          o_ctrl.alu_op    = ALU_OP_JUMP;
        end
        OP_JALR: begin
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.jalr      = 1'b1;
          o_ctrl.alu_op    = ALU_OP_JUMP;
          o_use_rs1        = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// ID->EX->MEM->WB control pipeline with load-use stall, redirect flush and forward selects.
// CTRL_MULDIV_EN adds a multi-cycle multiply hold in EX driven by a down-counter.
module decode_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [6:0]        id_funct7,
  input  logic [2:0]        id_funct3,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_redirect,
  output logic              stall,
  output logic              flush_ifid,
  output ctrl_t             ex_ctrl,
  output ctrl_t             mem_ctrl,
  output ctrl_t             wb_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] mem_rd,
  output logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  ctrl_t             r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
  logic [REG_AW-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
  logic [REG_AW-1:0] r_ex_rs1, r_ex_rs2;

  ctrl_t w_id_ctrl;
  logic  w_use_rs1, w_use_rs2;
  logic  w_lu_hazard, w_mul_busy, w_hold_ex, w_ex_load;
  logic  w_unused_funct3;

  assign w_unused_funct3 = ^id_funct3;

  ctrl_decode u_decode (
    .i_valid   (id_valid),
    .i_opcode  (id_opcode),
    .i_funct7  (id_funct7),
    .o_ctrl    (w_id_ctrl),
    .o_use_rs1 (w_use_rs1),
    .o_use_rs2 (w_use_rs2)
  );

  assign w_lu_hazard = r_ex_ctrl.mem_read && (r_ex_rd != '0) &&
                       ((w_use_rs1 && (id_rs1 == r_ex_rd)) ||
                        (w_use_rs2 && (id_rs2 == r_ex_rd)));

`ifdef CTRL_MULDIV_EN
  localparam logic [3:0] MUL_STALLS = 4'(MUL_LAT - 1);
  logic [3:0] r_mul_cnt;

  // Loaded as the multiply enters EX; nonzero means EX is still busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_mul_cnt <= '0;
    else if (ex_redirect)
      r_mul_cnt <= '0;
    else if (w_mul_busy)
      r_mul_cnt <= r_mul_cnt - 4'd1;
    else if (w_ex_load && w_id_ctrl.mul)
      r_mul_cnt <= MUL_STALLS;
  end

  assign w_mul_busy = (r_mul_cnt != '0);
`else
  logic [3:0] w_unused_lat;
  assign w_unused_lat = 4'(MUL_LAT);
  assign w_mul_busy   = 1'b0;
`endif

  // A redirect wins over both hazard sources: the ID instruction is discarded anyway.
  assign w_hold_ex  = w_mul_busy && !ex_redirect;
  assign w_ex_load  = !ex_redirect && !w_mul_busy && !w_lu_hazard;
  assign stall      = (w_lu_hazard || w_mul_busy) && !ex_redirect;
  assign flush_ifid = ex_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_ctrl  <= '0;
      r_mem_ctrl <= '0;
      r_wb_ctrl  <= '0;
      r_ex_rd    <= '0;
      r_mem_rd   <= '0;
      r_wb_rd    <= '0;
      r_ex_rs1   <= '0;
      r_ex_rs2   <= '0;
    end else begin
      r_wb_ctrl <= r_mem_ctrl;
      r_wb_rd   <= r_mem_rd;
      if (w_hold_ex) begin
        r_mem_ctrl <= '0;
        r_mem_rd   <= '0;
      end else begin
        r_mem_ctrl <= r_ex_ctrl;
        r_mem_rd   <= r_ex_rd;
        if (w_ex_load) begin
          r_ex_ctrl <= w_id_ctrl;
          r_ex_rd   <= id_rd;
          r_ex_rs1  <= id_rs1;
          r_ex_rs2  <= id_rs2;
        end else begin
          r_ex_ctrl <= '0;
          r_ex_rd   <= '0;
          r_ex_rs1  <= '0;
          r_ex_rs2  <= '0;
        end
      end
    end
  end

  function automatic logic [1:0] fwd_sel(
    input ctrl_t             mc,
    input logic [REG_AW-1:0] md,
    input ctrl_t             wc,
    input logic [REG_AW-1:0] wd,
    input logic [REG_AW-1:0] rs
  );
    if (mc.reg_write && (md != '0) && (md == rs))
      return FWD_MEM;
    if (wc.reg_write && (wd != '0) && (wd == rs))
      return FWD_WB;
    return FWD_NONE;
  endfunction

  assign fwd_a = fwd_sel(r_mem_ctrl, r_mem_rd, r_wb_ctrl, r_wb_rd, r_ex_rs1);
  assign fwd_b = fwd_sel(r_mem_ctrl, r_mem_rd, r_wb_ctrl, r_wb_rd, r_ex_rs2);

  assign ex_ctrl  = r_ex_ctrl;
  assign mem_ctrl = r_mem_ctrl;
  assign wb_ctrl  = r_wb_ctrl;
  assign ex_rd    = r_ex_rd;
  assign mem_rd   = r_mem_rd;
  assign wb_rd    = r_wb_rd;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: stimulus pushes per-cycle expectations, a negedge
// monitor pops and compares them. Multiply cases run when CTRL_MULDIV_EN is defined.
module tb_decode_ctrl_pipe;
  import ctrl_pkg::*;

  localparam logic [5:0] M_ALL  = 6'h3F;
  localparam logic [5:0] M_BASE = 6'h1F;

  localparam logic [6:0] F7_0   = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  // Bit order: alu_src mem_to_reg reg_write mem_read mem_write branch jal jalr lui auipc alu_op[1:0] mul
  localparam logic [12:0] C_ZERO = 13'b0_0_0_0_0_0_0_0_0_0_00_0;
  localparam logic [12:0] C_R    = 13'b0_0_1_0_0_0_0_0_0_0_10_0;
  localparam logic [12:0] C_I    = 13'b1_0_1_0_0_0_0_0_0_0_10_0;
  localparam logic [12:0] C_LW   = 13'b1_1_1_1_0_0_0_0_0_0_00_0;
`ifdef CTRL_MULDIV_EN
  localparam logic [12:0] C_MUL  = 13'b0_0_1_0_0_0_0_0_0_0_10_1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [6:0] id_opcode, id_funct7;
  logic [2:0] id_funct3;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_redirect;
  logic       stall, flush_ifid;
  ctrl_t      ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic [1:0] fwd_a, fwd_b;

  typedef struct {
    string       nm;
    logic [5:0]  m;
    logic        st;
    logic        fl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [12:0] ex;
    logic [12:0] mem;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  decode_ctrl_pipe #(.REG_AW(5), .MUL_LAT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_funct7   (id_funct7),
    .id_funct3   (id_funct3),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .ex_redirect (ex_redirect),
    .stall       (stall),
    .flush_ifid  (flush_ifid),
    .ex_ctrl     (ex_ctrl),
    .mem_ctrl    (mem_ctrl),
    .wb_ctrl     (wb_ctrl),
    .ex_rd       (ex_rd),
    .mem_rd      (mem_rd),
    .wb_rd       (wb_rd),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [6:0] op, input logic [6:0] f7,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic redir);
    @(posedge clk);
    #1;
    id_valid    = v;
    id_opcode   = op;
    id_funct7   = f7;
    id_funct3   = 3'b000;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    ex_redirect = redir;
  endtask

  task automatic bubble();
    drive(1'b0, 7'b0, F7_0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic push_exp(input string nm, input logic [5:0] m, input logic st, input logic fl,
                          input logic [1:0] fa, input logic [1:0] fb,
                          input logic [12:0] ex, input logic [12:0] mem);
    exp_t e;
    e.nm = nm; e.m = m; e.st = st; e.fl = fl;
    e.fa = fa; e.fb = fb; e.ex = ex; e.mem = mem;
    sb_q.push_back(e);
  endtask

  task automatic cmp(input string nm, input string fld, input logic [12:0] act, input logic [12:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s got=%0h expected=%0h", nm, fld, act, req);
    end
  endtask

  // Monitor: compare every pending expectation against the DUT at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.m[0]) cmp(e.nm, "stall", 13'(stall), 13'(e.st));
        if (e.m[1]) cmp(e.nm, "flush_ifid", 13'(flush_ifid), 13'(e.fl));
        if (e.m[2]) cmp(e.nm, "fwd_a", 13'(fwd_a), 13'(e.fa));
        if (e.m[3]) cmp(e.nm, "fwd_b", 13'(fwd_b), 13'(e.fb));
        if (e.m[4]) cmp(e.nm, "ex_ctrl", 13'(ex_ctrl), e.ex);
        if (e.m[5]) cmp(e.nm, "mem_ctrl", 13'(mem_ctrl), e.mem);
        $display("txn %-14s stall=%b flush=%b fwd=%b/%b ex=%h mem=%h wb=%h rd=%0d/%0d/%0d",
                 e.nm, stall, flush_ifid, fwd_a, fwd_b, ex_ctrl, mem_ctrl, wb_ctrl,
                 ex_rd, mem_rd, wb_rd);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; id_opcode = '0; id_funct7 = '0; id_funct3 = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_redirect = 1'b0;

    bubble();                  push_exp("reset", M_ALL, 0, 0, 2'b00, 2'b00, C_ZERO, C_ZERO);
    bubble(); rst_n = 1'b1;    push_exp("idle",  M_ALL, 0, 0, 2'b00, 2'b00, C_ZERO, C_ZERO);

    // LW x5 then ADD x6,x5,x7
    drive(1, OP_LW, F7_0, 5'd1, 5'd0, 5'd5, 0); push_exp("lu_lw",     M_BASE, 0, 0, 2'b00, 2'b00, C_ZERO, C_ZERO);
    drive(1, OP_R,  F7_0, 5'd5, 5'd7, 5'd6, 0); push_exp("lu_stall",  M_BASE, 1, 0, 2'b00, 2'b00, C_LW,   C_ZERO);
    drive(1, OP_R,  F7_0, 5'd5, 5'd7, 5'd6, 0); push_exp("lu_bubble", M_ALL,  0, 0, 2'b00, 2'b00, C_ZERO, C_LW);
    bubble();                                   push_exp("lu_fwd",    M_BASE, 0, 0, 2'b01, 2'b00, C_R,    C_ZERO);

    // ADDI x3 then SUB x4,x3,x3
    drive(1, OP_I, F7_0,   5'd2, 5'd0, 5'd3, 0); push_exp("addi_issue", M_BASE, 0, 0, 2'b00, 2'b00, C_ZERO, C_ZERO);
    drive(1, OP_R, F7_SUB, 5'd3, 5'd3, 5'd4, 0); push_exp("sub_issue",  M_BASE, 0, 0, 2'b00, 2'b00, C_I,    C_ZERO);
    bubble();                                    push_exp("sub_fwd",    M_BASE, 0, 0, 2'b10, 2'b10, C_R,    C_ZERO);

    // Load-use hazard coinciding with a redirect
    drive(1, OP_LW, F7_0, 5'd1,  5'd0, 5'd10, 0); push_exp("rd_lw",       M_BASE, 0, 0, 2'b00, 2'b00, C_ZERO, C_ZERO);
    drive(1, OP_R,  F7_0, 5'd10, 5'd0, 5'd11, 1); push_exp("rd_override", M_BASE, 0, 1, 2'b00, 2'b00, C_LW,   C_ZERO);
    bubble();                                     push_exp("rd_flushed",  M_ALL,  0, 0, 2'b00, 2'b00, C_ZERO, C_LW);

    // LW x0 then ADD x1,x0,x2
    drive(1, OP_LW, F7_0, 5'd1, 5'd0, 5'd0, 0); push_exp("x0_lw",      M_BASE, 0, 0, 2'b00, 2'b00, C_ZERO, C_ZERO);
    drive(1, OP_R,  F7_0, 5'd0, 5'd2, 5'd1, 0); push_exp("x0_nostall", M_BASE, 0, 0, 2'b00, 2'b00, C_LW,   C_ZERO);
    bubble();                                   push_exp("x0_nofwd",   M_BASE, 0, 0, 2'b00, 2'b00, C_R,    C_ZERO);

`ifdef CTRL_MULDIV_EN
    // MUL x8,x1,x2 then ADD x9,x8,x0; WB still holds ADD x1 during the first stall cycle
    drive(1, OP_R, F7_MUL, 5'd1, 5'd2, 5'd8, 0); push_exp("mul_issue",  M_BASE, 0, 0, 2'b00, 2'b00, C_ZERO, C_ZERO);
    drive(1, OP_R, F7_0,   5'd8, 5'd0, 5'd9, 0); push_exp("mul_stall1", M_ALL,  1, 0, 2'b01, 2'b00, C_MUL,  C_ZERO);
    drive(1, OP_R, F7_0,   5'd8, 5'd0, 5'd9, 0); push_exp("mul_stall2", M_ALL,  1, 0, 2'b00, 2'b00, C_MUL,  C_ZERO);
    drive(1, OP_R, F7_0,   5'd8, 5'd0, 5'd9, 0); push_exp("mul_last",   M_ALL,  0, 0, 2'b00, 2'b00, C_MUL,  C_ZERO);
    bubble();                                    push_exp("mul_fwd",    M_ALL,  0, 0, 2'b10, 2'b00, C_R,    C_MUL);

    // Reset in the middle of a multiply stall
    drive(1, OP_R, F7_MUL, 5'd1, 5'd2, 5'd8, 0); push_exp("rmul_issue", M_BASE, 0, 0, 2'b00, 2'b00, C_ZERO, C_ZERO);
    drive(1, OP_R, F7_0,   5'd8, 5'd0, 5'd9, 0); push_exp("rmul_stall", M_BASE, 1, 0, 2'b00, 2'b00, C_MUL,  C_ZERO);
    drive(1, OP_R, F7_0,   5'd8, 5'd0, 5'd9, 0); rst_n = 1'b0;
    push_exp("rst_mid_mul", M_ALL, 0, 0, 2'b00, 2'b00, C_ZERO, C_ZERO);
`else
    // funct7=0000001 is an ordinary R-type here
    drive(1, OP_R, F7_MUL, 5'd1, 5'd2, 5'd8, 0); push_exp("r_f7_issue", M_BASE, 0, 0, 2'b00, 2'b00, C_ZERO, C_ZERO);
    drive(1, OP_R, F7_0,   5'd8, 5'd0, 5'd9, 0); push_exp("r_f7_plain", M_ALL,  0, 0, 2'b01, 2'b00, C_R,    C_ZERO);
    bubble();                                    push_exp("r_f7_fwd",   M_ALL,  0, 0, 2'b10, 2'b00, C_R,    C_R);

    // Reset in the middle of a load-use stall
    drive(1, OP_LW, F7_0, 5'd1, 5'd0, 5'd5, 0); push_exp("rlu_lw",    M_BASE, 0, 0, 2'b00, 2'b00, C_ZERO, C_ZERO);
    drive(1, OP_R,  F7_0, 5'd5, 5'd7, 5'd6, 0); push_exp("rlu_stall", M_BASE, 1, 0, 2'b00, 2'b00, C_LW,   C_ZERO);
    @(negedge clk); #1; rst_n = 1'b0;
    drive(1, OP_R, F7_0, 5'd5, 5'd7, 5'd6, 0);
    push_exp("rst_mid_stall", M_ALL, 0, 0, 2'b00, 2'b00, C_ZERO, C_ZERO);
`endif

    drive(1, OP_I, F7_0, 5'd1, 5'd0, 5'd12, 0); rst_n = 1'b1;
    push_exp("rst_release", M_ALL, 0, 0, 2'b00, 2'b00, C_ZERO, C_ZERO);
    bubble();
    push_exp("rst_addi", M_BASE, 0, 0, 2'b00, 2'b00, C_I, C_ZERO);

    bubble();
    bubble();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
